celement_mg_sync: RTL and testbench
===================================

CELEMENT_MG_SYNC -- requirements
Module: celement_mg_sync

Interface
REQ-001 CLK  input  1  single system clock; all state updates on the rising edge.
REQ-002 RESETN  input  1  reset, asynchronous, active-low.
REQ-003 SENDINA  input  1  request from source A; 4-phase; asynchronous to CLK.
REQ-004 SENDINB  input  1  request from source B; 4-phase; asynchronous to CLK.
REQ-005 ACKOUTA  output  1  acknowledge to source A; registered.
REQ-006 ACKOUTB  output  1  acknowledge to source B; registered.
REQ-007 SENDOUT  output  1  merged request to the sink; registered.
REQ-008 ACKIN  input  1  acknowledge from the sink; asynchronous to CLK.
REQ-009 BROUT  output  1  source of the current token (0=A, 1=B), for the downstream branch BRIN; registered.
REQ-010 CP  output  1  one-cycle pulse per completed transfer.
REQ-011 ERR  output  1  sticky protocol-violation flag.

Function
REQ-012 SENDINA, SENDINB and ACKIN SHALL each pass through a 2-flop synchronizer; all rules below use the synchronized values SA, SB, AK.
REQ-013 FSM states SHALL be IDLE, FWD, ACKED and RELEASE.
REQ-014 IDLE: SENDOUT=0, ACKOUTA=ACKOUTB=0.
- If (SA or SB) and AK=0: register SEL, set BROUT=SEL, go to FWD.
- Otherwise stay in IDLE.
REQ-015 Arbitration:
- Only SA=1: SEL=A.
- Only SB=1: SEL=B.
- Both: SEL = the source not served last (round-robin); LAST updates to SEL on every grant.
REQ-016 FWD: SENDOUT=1.
- AK=1: go to ACKED; assert CP for exactly that one cycle.
REQ-017 ACKED: SENDOUT=1, ACKOUT[SEL]=1; the other ACKOUT stays 0.
- Synchronized SEND of SEL = 0: go to RELEASE.
REQ-018 RELEASE: SENDOUT=0, ACKOUT[SEL]=1.
- AK=0: go to IDLE; ACKOUT[SEL] falls on entry to IDLE.
REQ-019 BROUT SHALL hold SEL from grant until the next grant; it never changes outside an IDLE->FWD transition.
REQ-020 At most one of ACKOUTA/ACKOUTB SHALL be 1 in any cycle.
REQ-021 The non-selected source SHALL remain pending, unacknowledged, and be served on the next IDLE evaluation.
REQ-022 Latency: a request visible on SENDINA while the block is idle SHALL produce SENDOUT=1 on the 3rd rising edge (2 synchronizer edges + 1 FSM edge).
REQ-023 Violations:
- Selected SEND falls while in FWD: set ERR=1, stay in FWD, continue to wait for AK.
- AK falls while in ACKED: set ERR=1, no state change.
- ERR clears only on reset.
REQ-024 In IDLE, AK=1 with a pending request SHALL block the grant until AK=0.

Reset
REQ-025 RESETN=0 SHALL asynchronously force:
- FSM=IDLE, SENDOUT=0, ACKOUTA=ACKOUTB=0, CP=0, ERR=0, BROUT=0
- LAST=B, so A wins the first tie
- all synchronizer flops to 0
REQ-026 Reset mid-handshake SHALL abandon the transfer; after release, a still-high SENDIN is treated as a new request.
REQ-027 Reset deassertion SHALL take effect on the next rising CLK edge; no output glitches during assertion.

Structure
REQ-028 A shared package SHALL hold:
- FSM state encoding (2 bits: IDLE=0, FWD=1, ACKED=2, RELEASE=3)
- source encoding constants SRC_A=0, SRC_B=1
REQ-029 A single sub-module sync2 (1-bit, 2-flop, async active-low reset to 0) SHALL be instantiated three times; all other logic lives in celement_mg_sync.

Verification
REQ-030 A-only: SENDINA rises -> SENDOUT=1 at edge 3, BROUT=0; ACKIN high -> CP one cycle, ACKOUTA=1; SENDINA low then ACKIN low -> back to IDLE, ACKOUTA=0.
REQ-031 Simultaneous SENDINA=SENDINB=1 right after reset -> A served first (BROUT=0), then B (BROUT=1) with no reset in between; ACKOUTB stays 0 during A's transfer.
REQ-032 Continuous requests on both sources for 6 transfers -> BROUT sequence 0,1,0,1,0,1; CP count 6.
REQ-033 SENDINA dropped while in FWD -> ERR=1 and stays 1 through later clean transfers until RESETN=0.
REQ-034 RESETN pulsed low while in ACKED -> SENDOUT, ACKOUTx, CP and BROUT 0 immediately, without a clock edge; SENDINB held high -> new grant to B after release.
REQ-035 Request raised while ACKIN is still high from the previous transfer -> no SENDOUT until 3 edges after ACKIN falls.

Source files
------------

// File: rtl/celement_mg_sync_pkg.sv
// Shared definitions for the two-source merge with round-robin arbitration.
package celement_mg_sync_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      ACKED   = 2'd2,
      RELEASE = 2'd3
   } state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // Pick the source to grant: a lone requester wins, a tie goes to the one not served last.
   function automatic logic arb_pick(input logic sa, input logic sb, input logic last);
      if (sa && sb) begin
         return ~last;
      end
      if (sb) begin
         return SRC_B;
      end
      return SRC_A;
   endfunction

endpackage

// File: rtl/celement_mg_sync_if.sv
// Handshake bundle between the two sources, the merge block and the sink.
interface celement_mg_sync_if;

   logic SENDINA;
   logic SENDINB;
   logic ACKOUTA;
   logic ACKOUTB;
   logic SENDOUT;
   logic ACKIN;
   logic BROUT;
   logic CP;
   logic ERR;

   // Environment side: sources and sink.
   modport master (
      output SENDINA, SENDINB, ACKIN,
      input  ACKOUTA, ACKOUTB, SENDOUT, BROUT, CP, ERR
   );

   // Merge block side.
   modport slave (
      input  SENDINA, SENDINB, ACKIN,
      output ACKOUTA, ACKOUTB, SENDOUT, BROUT, CP, ERR
   );

endinterface

// File: rtl/celement_mg_sync_sync2.sv
// Two-flop synchronizer for one asynchronous control line, clears to 0 on reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: shift the input through the two stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer stages with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/celement_mg_sync.sv
// Synchronous merge of two 4-phase requesters onto one sink, round-robin on ties.
module celement_mg_sync
   import celement_mg_sync_pkg::*;
(
   input logic               CLK,
   input logic               RESETN,
   celement_mg_sync_if.slave bus
);

   logic   sa, sb, ak;
   logic   sel_send;

   state_e state_q, state_d;
   logic   sel_q, sel_d;
   logic   last_q, last_d;
   logic   sendout_q, sendout_d;
   logic   acka_q, acka_d;
   logic   ackb_q, ackb_d;
   logic   cp_q, cp_d;
   logic   err_q, err_d;

   sync2 u_sync_a (.clk(CLK), .rst_n(RESETN), .d(bus.SENDINA), .q(sa));
   sync2 u_sync_b (.clk(CLK), .rst_n(RESETN), .d(bus.SENDINB), .q(sb));
   sync2 u_sync_k (.clk(CLK), .rst_n(RESETN), .d(bus.ACKIN),   .q(ak));

   assign sel_send = (sel_q == SRC_B) ? sb : sa;

   // Handshake sequencing: grant, forward, acknowledge the source, release.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      sendout_d = sendout_q;
      acka_d    = acka_q;
      ackb_d    = ackb_q;
      cp_d      = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            sendout_d = 1'b0;
            acka_d    = 1'b0;
            ackb_d    = 1'b0;
            // A lingering sink acknowledge holds off any new grant.
            if ((sa || sb) && !ak) begin
               sel_d     = arb_pick(sa, sb, last_q);
               last_d    = sel_d;
               sendout_d = 1'b1;
               state_d   = FWD;
            end
         end
         FWD: begin
            if (!sel_send) begin
               err_d = 1'b1;
            end
            if (ak) begin
               state_d = ACKED;
               cp_d    = 1'b1;
               acka_d  = (sel_q == SRC_A);
               ackb_d  = (sel_q == SRC_B);
            end
         end
         ACKED: begin
            // A premature sink release is flagged and otherwise ignored.
            if (!ak) begin
               err_d = 1'b1;
            end else if (!sel_send) begin
               sendout_d = 1'b0;
               state_d   = RELEASE;
            end
         end
         RELEASE: begin
            if (!ak) begin
               acka_d  = 1'b0;
               ackb_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs, all cleared asynchronously on reset.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= IDLE;
         sel_q     <= SRC_A;
         last_q    <= SRC_B;
         sendout_q <= 1'b0;
         acka_q    <= 1'b0;
         ackb_q    <= 1'b0;
         cp_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         sendout_q <= sendout_d;
         acka_q    <= acka_d;
         ackb_q    <= ackb_d;
         cp_q      <= cp_d;
         err_q     <= err_d;
      end
   end

   assign bus.SENDOUT = sendout_q;
   assign bus.ACKOUTA = acka_q;
   assign bus.ACKOUTB = ackb_q;
   assign bus.BROUT   = sel_q;
   assign bus.CP      = cp_q;
   assign bus.ERR     = err_q;

endmodule

// File: tb/tb_celement_mg_sync.sv
// Bench for celement_mg_sync: directed handshake scenarios plus a randomized
// multi-source run checked against a transaction-level arbitration model.
module tb_celement_mg_sync;

   localparam int S_SENDOUT = 0;
   localparam int S_ACKA    = 1;
   localparam int S_ACKB    = 2;
   localparam int S_CP      = 3;
   localparam int S_BROUT   = 4;
   localparam int S_ERR     = 5;

   logic CLK    = 1'b0;
   logic RESETN = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cp_cnt   = 0;

   // Random-phase agent state.
   int   sst[2];
   int   sgap[2];
   logic req[2];
   int   req_edge[2];

   celement_mg_sync_if bus ();

   celement_mg_sync dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.CP) cp_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sig(input int which);
      case (which)
         S_SENDOUT: return int'(bus.SENDOUT);
         S_ACKA:    return int'(bus.ACKOUTA);
         S_ACKB:    return int'(bus.ACKOUTB);
         S_CP:      return int'(bus.CP);
         S_BROUT:   return int'(bus.BROUT);
         default:   return int'(bus.ERR);
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_for(input string tag, input int which, input int val, input int budget);
      int i;
      i = 0;
      while (sig(which) != val && i < budget) begin
         step(1);
         i++;
      end
      if (sig(which) != val) check(tag, sig(which), val);
   endtask

   task automatic set_send(input logic src, input logic v);
      if (src) bus.SENDINB = v;
      else     bus.SENDINA = v;
   endtask

   task automatic do_reset();
      bus.SENDINA = 1'b0;
      bus.SENDINB = 1'b0;
      bus.ACKIN   = 1'b0;
      RESETN      = 1'b0;
      step(2);
      RESETN      = 1'b1;
   endtask

   // Sink completes one transfer for the granted source; optionally re-request.
   task automatic serve(input logic src, input logic reraise);
      bus.ACKIN = 1'b1;
      wait_for("srv_ack", src ? S_ACKB : S_ACKA, 1, 12);
      check("srv_other_ack", sig(src ? S_ACKA : S_ACKB), 0);
      check("srv_brout", sig(S_BROUT), int'(src));
      set_send(src, 1'b0);
      wait_for("srv_release", S_SENDOUT, 0, 12);
      check("srv_ack_hold", sig(src ? S_ACKB : S_ACKA), 1);
      bus.ACKIN = 1'b0;
      wait_for("srv_done", src ? S_ACKB : S_ACKA, 0, 12);
      check("srv_idle_sendout", sig(S_SENDOUT), 0);
      if (reraise) set_send(src, 1'b1);
   endtask

   task automatic src_agent(input logic s, input int e, input logic stop);
      logic ack_s;
      ack_s = s ? bus.ACKOUTB : bus.ACKOUTA;
      case (sst[s])
         0: if (!stop) begin
               if (sgap[s] == 0) begin
                  set_send(s, 1'b1);
                  req[s]      = 1'b1;
                  req_edge[s] = e + 1;
                  sst[s]      = 1;
               end else begin
                  sgap[s]--;
               end
            end
         1: if (ack_s) begin
               set_send(s, 1'b0);
               req[s] = 1'b0;
               sst[s] = 2;
            end
         default: if (!ack_s) begin
               sgap[s] = int'($urandom_range(0, 5));
               sst[s]  = 0;
            end
      endcase
   endtask

   initial begin
      int   c0;
      logic src;
      int   e;
      int   budget;
      int   grants;
      int   cps;
      int   sink_st;
      int   sink_dly;
      logic last_m;
      logic exp_src;
      logic vis_a;
      logic vis_b;
      logic stop;
      logic done;
      logic sendout_prev;

      // Reset state.
      bus.SENDINA = 1'b1;
      bus.SENDINB = 1'b1;
      bus.ACKIN   = 1'b1;
      RESETN      = 1'b0;
      step(3);
      for (int w = 0; w < 6; w++) check("reset_out", sig(w), 0);

      // A-only transfer with exact request latency.
      do_reset();
      bus.SENDINA = 1'b1;
      step(2);
      check("lat_edge2", sig(S_SENDOUT), 0);
      step(1);
      check("lat_edge3", sig(S_SENDOUT), 1);
      check("a_brout", sig(S_BROUT), 0);
      bus.ACKIN = 1'b1;
      wait_for("a_cp", S_CP, 1, 12);
      check("a_acka_at_cp", sig(S_ACKA), 1);
      check("a_ackb_at_cp", sig(S_ACKB), 0);
      step(1);
      check("a_cp_one_cycle", sig(S_CP), 0);
      check("a_acka_hold", sig(S_ACKA), 1);
      bus.SENDINA = 1'b0;
      wait_for("a_release", S_SENDOUT, 0, 12);
      check("a_acka_release", sig(S_ACKA), 1);
      bus.ACKIN = 1'b0;
      wait_for("a_idle", S_ACKA, 0, 12);
      check("a_err", sig(S_ERR), 0);

      // Simultaneous requests after reset: A then B.
      do_reset();
      bus.SENDINA = 1'b1;
      bus.SENDINB = 1'b1;
      wait_for("tie_grant_a", S_SENDOUT, 1, 8);
      check("tie_first_a", sig(S_BROUT), 0);
      serve(1'b0, 1'b0);
      wait_for("tie_grant_b", S_SENDOUT, 1, 12);
      check("tie_then_b", sig(S_BROUT), 1);
      serve(1'b1, 1'b0);

      // Continuous requests on both: strict alternation, one CP per transfer.
      do_reset();
      bus.SENDINA = 1'b1;
      bus.SENDINB = 1'b1;
      c0 = cp_cnt;
      for (int i = 0; i < 6; i++) begin
         src = (i % 2 == 1);
         wait_for("rr_grant", S_SENDOUT, 1, 12);
         check("rr_brout", sig(S_BROUT), i % 2);
         serve(src, 1'b1);
      end
      check("rr_cp_count", cp_cnt - c0, 6);

      // Request withdrawn while forwarding: sticky ERR until reset.
      do_reset();
      bus.SENDINA = 1'b1;
      wait_for("err_grant", S_SENDOUT, 1, 8);
      check("err_before", sig(S_ERR), 0);
      bus.SENDINA = 1'b0;
      step(4);
      check("err_set", sig(S_ERR), 1);
      check("err_stay_fwd", sig(S_SENDOUT), 1);
      check("err_no_acka", sig(S_ACKA), 0);
      bus.ACKIN = 1'b1;
      wait_for("err_acked", S_ACKA, 1, 12);
      wait_for("err_release", S_SENDOUT, 0, 12);
      bus.ACKIN = 1'b0;
      wait_for("err_idle", S_ACKA, 0, 12);
      bus.SENDINB = 1'b1;
      wait_for("err_grant_b", S_SENDOUT, 1, 12);
      serve(1'b1, 1'b0);
      check("err_sticky", sig(S_ERR), 1);
      @(negedge CLK);
      RESETN = 1'b0;
      #1;
      check("err_cleared", sig(S_ERR), 0);
      step(1);
      RESETN = 1'b1;

      // Reset during ACKED clears outputs without a clock edge; B re-granted.
      do_reset();
      bus.SENDINB = 1'b1;
      wait_for("rst_grant", S_SENDOUT, 1, 8);
      check("rst_pre_brout", sig(S_BROUT), 1);
      bus.ACKIN = 1'b1;
      wait_for("rst_acked", S_ACKB, 1, 12);
      @(negedge CLK);
      RESETN = 1'b0;
      #1;
      check("rst_async_sendout", sig(S_SENDOUT), 0);
      check("rst_async_ackb", sig(S_ACKB), 0);
      check("rst_async_cp", sig(S_CP), 0);
      check("rst_async_brout", sig(S_BROUT), 0);
      bus.ACKIN = 1'b0;
      step(2);
      RESETN = 1'b1;
      wait_for("rst_regrant", S_SENDOUT, 1, 8);
      check("rst_regrant_b", sig(S_BROUT), 1);
      serve(1'b1, 1'b0);

      // Sink acknowledge still high in IDLE blocks the grant until 3 edges after it falls.
      do_reset();
      bus.ACKIN = 1'b1;
      step(3);
      bus.SENDINA = 1'b1;
      step(6);
      check("blk_hold", sig(S_SENDOUT), 0);
      bus.ACKIN = 1'b0;
      step(2);
      check("blk_edge2", sig(S_SENDOUT), 0);
      step(1);
      check("blk_edge3", sig(S_SENDOUT), 1);
      check("blk_brout", sig(S_BROUT), 0);
      serve(1'b0, 1'b0);

      // Randomized traffic against an arbitration model.
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sst[s]      = 0;
         sgap[s]     = int'($urandom_range(0, 5));
         req[s]      = 1'b0;
         req_edge[s] = 0;
      end
      sink_st      = 0;
      sink_dly     = int'($urandom_range(0, 4));
      last_m       = 1'b1;
      grants       = 0;
      cps          = 0;
      e            = 0;
      budget       = 0;
      stop         = 1'b0;
      done         = 1'b0;
      sendout_prev = 1'b0;
      while (budget < 8000 && !done) begin
         step(1);
         e++;
         budget++;
         if (bus.SENDOUT && !sendout_prev) begin
            vis_a   = req[0] && (req_edge[0] <= e - 2);
            vis_b   = req[1] && (req_edge[1] <= e - 2);
            exp_src = (vis_a && vis_b) ? ~last_m : vis_b;
            check("rnd_grant_visible", int'(vis_a | vis_b), 1);
            check("rnd_brout", sig(S_BROUT), int'(exp_src));
            last_m = exp_src;
            grants++;
         end
         sendout_prev = bus.SENDOUT;
         if (bus.CP) cps++;
         if (bus.ACKOUTA || bus.ACKOUTB)
            check("rnd_ack_sel", int'({bus.ACKOUTA, bus.ACKOUTB}), bus.BROUT ? 1 : 2);
         src_agent(1'b0, e, stop);
         src_agent(1'b1, e, stop);
         if (sink_st == 0) begin
            if (bus.SENDOUT) begin
               if (sink_dly == 0) begin
                  bus.ACKIN = 1'b1;
                  sink_st   = 1;
                  sink_dly  = int'($urandom_range(0, 4));
               end else begin
                  sink_dly--;
               end
            end
         end else if (!bus.SENDOUT) begin
            if (sink_dly == 0) begin
               bus.ACKIN = 1'b0;
               sink_st   = 0;
               sink_dly  = int'($urandom_range(0, 4));
            end else begin
               sink_dly--;
            end
         end
         if (grants >= 40) stop = 1'b1;
         if (stop && sst[0] == 0 && sst[1] == 0 && sink_st == 0 && !bus.ACKIN &&
             !bus.SENDOUT && !bus.ACKOUTA && !bus.ACKOUTB)
            done = 1'b1;
      end
      check("rnd_completed", int'(done), 1);
      check("rnd_cp_per_grant", cps, grants);
      check("rnd_err", sig(S_ERR), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
